// File: rtl/extbus_pkg.sv
// Shared defaults for the external bus exchange register file.
package extbus_pkg;
  localparam int WORD_W = 72;
  localparam int TAG_W  = 8;
  localparam int NIB_W  = 4;

  typedef logic [NIB_W-1:0] nibble_t;
endpackage

// File: rtl/extbus_lane.sv
// One 4-bit slice of the register file: storage, priority write merge,
// write-through read registers and a same-cycle collision flag.
module extbus_lane
  import extbus_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NPORTS = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       en,
  input  logic [NPORTS-1:0]       we,
  input  logic [NPORTS*AW-1:0]    addr,
  input  logic [NPORTS-1:0]       nib_we,
  input  logic [NPORTS*NIB_W-1:0] wdata,
  output logic [NPORTS*NIB_W-1:0] rdata,
  output logic                    collision
);

  nibble_t          mem [DEPTH];
  nibble_t          nxt [DEPTH];
  logic [DEPTH-1:0] taken;

  // Lowest-index writer claims the nibble; later writers to a claimed entry collide.
  always_comb begin
    nxt       = mem;
    taken     = '0;
    collision = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (en[p] & we[p] & nib_we[p]) begin
        if (taken[addr[p*AW +: AW]]) begin
          collision = 1'b1;
        end else begin
          nxt[addr[p*AW +: AW]]   = wdata[p*NIB_W +: NIB_W];
          taken[addr[p*AW +: AW]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      mem <= nxt;
      for (int p = 0; p < NPORTS; p++) begin
        if (en[p]) rdata[p*NIB_W +: NIB_W] <= nxt[addr[p*AW +: AW]];
      end
    end
  end

endmodule

// File: rtl/extbus_rf.sv
// Multi-port bus exchange register file built from nibble lanes, with a
// sticky write-collision flag.
module extbus_rf
  import extbus_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int DEPTH  = 4,
  parameter int NPORTS = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int NNIB  = WIDTH / NIB_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       en,
  input  logic [NPORTS-1:0]       we,
  input  logic [NPORTS*AW-1:0]    addr,
  input  logic [NPORTS*NNIB-1:0]  nib_we,
  input  logic [NPORTS*WIDTH-1:0] wdata,
  output logic [NPORTS*WIDTH-1:0] rdata,
  output logic                    conflict,
  input  logic                    conflict_clr
);

  if (WIDTH % NIB_W != 0 || WIDTH < TAG_W) begin : g_bad_width
    $error("extbus_rf: WIDTH must be a nibble multiple wide enough for the tag");
  end

  logic [NNIB-1:0] lane_coll;

  for (genvar k = 0; k < NNIB; k++) begin : g_lane
    logic [NPORTS-1:0]       lnib;
    logic [NPORTS*NIB_W-1:0] lwd;
    logic [NPORTS*NIB_W-1:0] lrd;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      assign lnib[p]                               = nib_we[p*NNIB + k];
      assign lwd[p*NIB_W +: NIB_W]                 = wdata[p*WIDTH + k*NIB_W +: NIB_W];
      assign rdata[p*WIDTH + k*NIB_W +: NIB_W]     = lrd[p*NIB_W +: NIB_W];
    end

    extbus_lane #(
      .DEPTH  (DEPTH),
      .NPORTS (NPORTS)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .we        (we),
      .addr      (addr),
      .nib_we    (lnib),
      .wdata     (lwd),
      .rdata     (lrd),
      .collision (lane_coll[k])
    );
  end

  // A new collision outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)           conflict <= 1'b0;
    else if (|lane_coll) conflict <= 1'b1;
    else if (conflict_clr) conflict <= 1'b0;
  end

endmodule

// File: tb/tb_extbus_rf.sv
// Scoreboard bench for extbus_rf: directed scenarios followed by random traffic.
module tb_extbus_rf;
  localparam int W  = 72;
  localparam int D  = 4;
  localparam int NP = 4;
  localparam int AW = 2;
  localparam int NN = W / 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     en, we;
  logic [NP*AW-1:0]  addr;
  logic [NP*NN-1:0]  nib_we;
  logic [NP*W-1:0]   wdata;
  logic [NP*W-1:0]   rdata;
  logic              conflict, conflict_clr;

  extbus_rf dut (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .nib_we(nib_we),
    .wdata(wdata), .rdata(rdata), .conflict(conflict), .conflict_clr(conflict_clr)
  );

  always #5 clk = ~clk;

  // per-port stimulus staging
  logic          s_rst, s_clr;
  logic          s_en [NP];
  logic          s_we [NP];
  logic [AW-1:0] s_addr [NP];
  logic [NN-1:0] s_mask [NP];
  logic [W-1:0]  s_wd [NP];

  // reference model state
  logic [W-1:0]  m_mem [D];
  logic [W-1:0]  m_rd [NP];
  logic          m_conf;

  typedef struct packed {
    logic [NP-1:0][W-1:0] rd;
    logic                 conf;
  } exp_t;

  exp_t exp_q [$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic idle_stage();
    s_rst = 1'b0; s_clr = 1'b0;
    for (int p = 0; p < NP; p++) begin
      s_en[p] = 1'b0; s_we[p] = 1'b0; s_addr[p] = '0; s_mask[p] = '0; s_wd[p] = '0;
    end
  endtask

  // Drive one cycle of staged stimulus and predict the response after the edge.
  task automatic apply();
    int   owner [D][NN];
    logic hit;
    exp_t e;
    @(negedge clk);
    reset = s_rst; conflict_clr = s_clr;
    for (int p = 0; p < NP; p++) begin
      en[p] = s_en[p]; we[p] = s_we[p];
      addr[p*AW +: AW] = s_addr[p];
      nib_we[p*NN +: NN] = s_mask[p];
      wdata[p*W +: W] = s_wd[p];
    end
    if (s_rst) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      for (int p = 0; p < NP; p++) m_rd[p] = '0;
      m_conf = 1'b0;
    end else begin
      hit = 1'b0;
      for (int i = 0; i < D; i++) for (int k = 0; k < NN; k++) owner[i][k] = -1;
      for (int p = 0; p < NP; p++) begin
        if (!(s_en[p] && s_we[p])) continue;
        for (int k = 0; k < NN; k++) begin
          if (!s_mask[p][k]) continue;
          if (owner[s_addr[p]][k] >= 0) hit = 1'b1;
          else owner[s_addr[p]][k] = p;
        end
      end
      for (int i = 0; i < D; i++)
        for (int k = 0; k < NN; k++)
          if (owner[i][k] >= 0) m_mem[i][4*k +: 4] = s_wd[owner[i][k]][4*k +: 4];
      for (int p = 0; p < NP; p++) if (s_en[p]) m_rd[p] = m_mem[s_addr[p]];
      if (hit) m_conf = 1'b1;
      else if (s_clr) m_conf = 1'b0;
    end
    for (int p = 0; p < NP; p++) e.rd[p] = m_rd[p];
    e.conf = m_conf;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every predicted response one step after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < NP; p++) begin
          vectors++;
          if (rdata[p*W +: W] !== e.rd[p]) begin
            miscompares++;
            $display("FAIL rdata[%0d] got %h expected %h at %0t", p, rdata[p*W +: W], e.rd[p], $time);
          end
        end
        vectors++;
        if (conflict !== e.conf) begin
          miscompares++;
          $display("FAIL conflict got %b expected %b at %0t", conflict, e.conf, $time);
        end
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1; conflict_clr = 1'b0; en = '0; we = '0; addr = '0; nib_we = '0; wdata = '0;
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    for (int p = 0; p < NP; p++) m_rd[p] = '0;
    m_conf = 1'b0;

    // reset, then idle reads of every address
    idle_stage(); s_rst = 1'b1; apply(); apply();
    idle_stage();
    for (int p = 0; p < NP; p++) begin s_en[p] = 1'b1; s_addr[p] = AW'(p); end
    apply();

    // basic write then read from another port
    idle_stage();
    s_en[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 2'd2; s_mask[1] = '1;
    s_wd[1] = 72'hAB_0123456789ABCDEF;
    apply();
    idle_stage(); s_en[3] = 1'b1; s_addr[3] = 2'd2; apply();

    // priority collision, then clear
    idle_stage();
    s_en[0] = 1'b1; s_we[0] = 1'b1; s_addr[0] = 2'd1; s_mask[0] = '1; s_wd[0] = {18{4'h1}};
    s_en[2] = 1'b1; s_we[2] = 1'b1; s_addr[2] = 2'd1; s_mask[2] = '1; s_wd[2] = {18{4'h2}};
    apply();
    idle_stage(); s_clr = 1'b1; s_en[1] = 1'b1; s_addr[1] = 2'd1; apply();

    // disjoint merge into the tag and data fields
    idle_stage();
    s_en[0] = 1'b1; s_we[0] = 1'b1; s_addr[0] = 2'd3; s_mask[0] = 18'h0FFFF; s_wd[0] = 72'hFF_000000000000FFFF;
    s_en[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 2'd3; s_mask[1] = 18'h30000; s_wd[1] = 72'h5A_FFFFFFFFFFFFFFFF;
    apply();
    idle_stage(); s_en[2] = 1'b1; s_addr[2] = 2'd3; apply();

    // same-cycle bypass with a disabled port holding
    idle_stage();
    s_en[2] = 1'b1; s_we[2] = 1'b1; s_addr[2] = 2'd0; s_mask[2] = '1; s_wd[2] = 72'h3C;
    s_en[0] = 1'b1; s_addr[0] = 2'd0;
    apply();

    // reset during a write discards it
    idle_stage();
    s_rst = 1'b1; s_en[0] = 1'b1; s_we[0] = 1'b1; s_addr[0] = 2'd1; s_mask[0] = '1; s_wd[0] = 72'h77;
    apply();
    idle_stage(); s_en[0] = 1'b1; s_addr[0] = 2'd1; apply();

    // random traffic: small address space makes collisions and bypass frequent
    for (int n = 0; n < 600; n++) begin
      idle_stage();
      s_rst = ($urandom_range(0, 59) == 0);
      s_clr = ($urandom_range(0, 5) == 0);
      for (int p = 0; p < NP; p++) begin
        s_en[p]   = ($urandom_range(0, 3) != 0);
        s_we[p]   = $urandom_range(0, 1) == 1;
        s_addr[p] = AW'($urandom_range(0, D - 1));
        case ($urandom_range(0, 3))
          0:       s_mask[p] = '1;
          1:       s_mask[p] = NN'(1) << $urandom_range(0, NN - 1);
          default: s_mask[p] = {NN'($urandom()) ^ (NN'($urandom()) << 9)};
        endcase
        s_wd[p] = {8'($urandom()), $urandom(), $urandom()};
      end
      apply();
    end

    idle_stage(); apply();
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
